kmap_sweep_ctrl: RTL and testbench
==================================

# kmap_sweep_ctrl

Sequencer that drives a combinational truth-table datapath, such as the 3-input K-map function blocks, through every input minterm in ascending order. It samples the datapath output for each minterm, assembles the captured truth table and counts the ones. It also compares the capture against an expected table, so one start pulse yields a pass/fail verdict and the first failing minterm. It sits between a control/register front-end and the function block under evaluation.

## Interface
Parameters:
- N_IN, 3, number of datapath inputs; legal 2..6; table width T = 2^N_IN.
- SETTLE, 1, cycles each minterm is held on `sel` before `f_in` is sampled; legal ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- areset  in  1  reset, asynchronous, active-high; forces IDLE and clears all state immediately.
- start  in  1  request a sweep; accepted only in IDLE or DONE.
- expected  in  T  expected truth table, bit i = f(i); latched at start acceptance.
- sel  out  N_IN  minterm index driven to the datapath; MSB is the first datapath input (N_IN=3: {a,b,c} = sel).
- f_in  in  1  datapath output for the current `sel`.
- busy  out  1  high while sweeping.
- done  out  1  level; high in DONE until next accepted start or reset.
- table  out  T  captured truth table; bit i = sampled f_in for sel=i.
- ones_count  out  N_IN+1  number of sampled minterms with f_in=1.
- mismatch  out  1  sticky; set when any sampled bit ≠ expected bit.
- first_err  out  N_IN  index of first mismatching minterm; 0 if none.

## Operation
- States: IDLE, SWEEP, DONE. Internal: idx (N_IN bits), wait counter wcnt (0..SETTLE-1), latched expected.
- IDLE/DONE + start: →SWEEP; idx←0, wcnt←0, table←0, ones_count←0, mismatch←0, first_err←0, expected latched; done←0.
- SWEEP, wcnt<SETTLE-1: wcnt++.
- SWEEP, wcnt=SETTLE-1 (sample edge):
  - table[idx] ← f_in; ones_count += f_in.
  - If f_in≠exp[idx] and mismatch=0: mismatch←1, first_err←idx.
  - If f_in≠exp[idx] and mismatch=1: first_err unchanged.
  - wcnt←0.
  - If idx=T-1: →DONE. Otherwise idx++.
- sel = idx in SWEEP, 0 in IDLE and DONE. busy = (state==SWEEP). done = (state==DONE).
- start in SWEEP: ignored; no restart, no latch of new expected.
- table/ones_count/mismatch/first_err update live during SWEEP. They are final and held in DONE.
- idx never wraps. ones_count is wide enough for T without overflow.
- areset at any time, including mid-sweep: all outputs and state 0, IDLE; sweep aborted, no partial result retained.

## Timing
- Start accepted at edge t0: busy=1, sel=0 from t0.
- Minterm i is on sel during cycles [t0+SETTLE·i, t0+SETTLE·(i+1)). It is sampled at edge t0+SETTLE·(i+1).
- Last sample edge t0+SETTLE·T: state→DONE, busy=0, done=1, sel=0, results final at that edge.
- Sweep latency: SETTLE·T cycles (N_IN=3, SETTLE=1: 8 cycles).
- Restart from DONE: start edge t1 clears results and done at t1; the next sweep follows the same timing.
- Reset values: sel=0, busy=0, done=0, table=0, ones_count=0, mismatch=0, first_err=0.
- Reset assertion takes effect without a clock edge. On deassertion, IDLE from the next edge.

## Test plan
- N_IN=3, SETTLE=1, f=a|b|c, expected=8'hFE, start pulse -> sel steps 0..7 one per cycle; done at t0+8; table=8'hFE, ones_count=7, mismatch=0, first_err=0.
- Same f, expected=8'h7E -> mismatch=1, first_err=7. Expected=8'hFF -> mismatch=1, first_err=0, with first_err not overwritten by later matches.
- SETTLE=3, f=a|b|c -> each sel value held exactly 3 cycles; done at t0+24; table=8'hFE.
- Start pulses at sweep cycles 2 and 5 -> ignored, sweep unchanged. Areset at cycle 4 -> all outputs 0 immediately, busy=0. Fresh start -> normal completion, table=8'hFE.
- From DONE, swap f to a&b&c and pulse start with expected=8'h80 -> done drops at start edge; final table=8'h80, ones_count=1, mismatch=0.
- N_IN=2, f=a|b (sel={a,b}), expected=4'hE -> 4-cycle sweep; table=4'hE, ones_count=3, ones_count width 3.

Source files
------------

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: steps a combinational truth-table datapath through every
// minterm in ascending order, captures f_in per minterm, counts the ones and
// compares the capture against a latched expected table.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset; sel=0, waiting for start
// S_SWEEP | minterm idx on sel, sampled when settle timer reaches zero
// S_DONE  | results final and held; start begins a new sweep
module kmap_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        sel,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   table_o,
  output logic [N_IN:0]          ones_count,
  output logic                   mismatch,
  output logic [N_IN-1:0]        first_err
);

  localparam int T  = 1 << N_IN;
  localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WW-1:0]   RELOAD = WW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = N_IN'(T - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [T-1:0]    exp_q, exp_d;
  logic [T-1:0]    tbl_q, tbl_d;
  logic [N_IN:0]   ones_q, ones_d;
  logic            mm_q, mm_d;
  logic [N_IN-1:0] ferr_q, ferr_d;

  // State and result registers; reset aborts any sweep and clears everything.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      ones_q  <= '0;
      mm_q    <= 1'b0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      ones_q  <= ones_d;
      mm_q    <= mm_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: start launches a sweep, settle down-counter gates each sample.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    ones_d  = ones_q;
    mm_d    = mm_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          wcnt_d  = RELOAD;
          exp_d   = expected;
          tbl_d   = '0;
          ones_d  = '0;
          mm_d    = 1'b0;
          ferr_d  = '0;
        end
      end
      S_SWEEP: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else begin
          tbl_d[idx_q] = f_in;
          ones_d       = ones_q + {{N_IN{1'b0}}, f_in};
          // Only the first miscompare is recorded; later ones leave first_err alone.
          if ((f_in != exp_q[idx_q]) && !mm_q) begin
            mm_d   = 1'b1;
            ferr_d = idx_q;
          end
          wcnt_d = RELOAD;
          if (idx_q == LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    sel        = (state_q == S_SWEEP) ? idx_q : '0;
    busy       = (state_q == S_SWEEP);
    done       = (state_q == S_DONE);
    table_o    = tbl_q;
    ones_count = ones_q;
    mismatch   = mm_q;
    first_err  = ferr_q;
  end

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Directed bench for kmap_sweep_ctrl: three instances (N_IN=3/SETTLE=1,
// N_IN=3/SETTLE=3, N_IN=2/SETTLE=1), each fed by a behavioural K-map function.
module tb_kmap_sweep_ctrl;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // N_IN=3, SETTLE=1
  logic       start3 = 1'b0;
  logic [7:0] expected3 = 8'h00;
  logic [2:0] sel3;
  logic       f3;
  logic       busy3, done3, mm3;
  logic [7:0] tbl3;
  logic [3:0] ones3;
  logic [2:0] fe3;
  logic       fand = 1'b0;
  assign f3 = fand ? (&sel3) : (|sel3);

  // N_IN=3, SETTLE=3
  logic       start3s = 1'b0;
  logic [7:0] expected3s = 8'h00;
  logic [2:0] sel3s;
  logic       f3s;
  logic       busy3s, done3s, mm3s;
  logic [7:0] tbl3s;
  logic [3:0] ones3s;
  logic [2:0] fe3s;
  assign f3s = |sel3s;

  // N_IN=2, SETTLE=1
  logic       start2 = 1'b0;
  logic [3:0] expected2 = 4'h0;
  logic [1:0] sel2;
  logic       f2;
  logic       busy2, done2, mm2;
  logic [3:0] tbl2;
  logic [2:0] ones2;
  logic [1:0] fe2;
  assign f2 = sel2[1] | sel2[0];

  kmap_sweep_ctrl #(.N_IN(3), .SETTLE(1)) u3 (
    .clk(clk), .areset(areset), .start(start3), .expected(expected3),
    .sel(sel3), .f_in(f3), .busy(busy3), .done(done3), .table_o(tbl3),
    .ones_count(ones3), .mismatch(mm3), .first_err(fe3));

  kmap_sweep_ctrl #(.N_IN(3), .SETTLE(3)) u3s (
    .clk(clk), .areset(areset), .start(start3s), .expected(expected3s),
    .sel(sel3s), .f_in(f3s), .busy(busy3s), .done(done3s), .table_o(tbl3s),
    .ones_count(ones3s), .mismatch(mm3s), .first_err(fe3s));

  kmap_sweep_ctrl #(.N_IN(2), .SETTLE(1)) u2 (
    .clk(clk), .areset(areset), .start(start2), .expected(expected2),
    .sel(sel2), .f_in(f2), .busy(busy2), .done(done2), .table_o(tbl2),
    .ones_count(ones2), .mismatch(mm2), .first_err(fe2));

  task automatic test_reset();
    #2;
    checks++; if ({busy3, done3, mm3} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy3, done3, mm3}); else passed++;
    checks++; if ({sel3, fe3} !== 6'd0) $display("FAIL reset_sel_ferr: got %h want 0", {sel3, fe3}); else passed++;
    checks++; if ({tbl3, ones3} !== 12'd0) $display("FAIL reset_tbl_ones: got %h want 0", {tbl3, ones3}); else passed++;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy3, done3, sel3} !== 5'd0) $display("FAIL reset_idle: got %h want 0", {busy3, done3, sel3}); else passed++;
  endtask

  // Full SETTLE=1 sweep on u3 with per-cycle sel tracking and final result checks.
  task automatic sweep3(input logic [7:0] exp_v, input logic [7:0] want_tbl,
                        input logic [3:0] want_ones, input logic want_mm,
                        input logic [2:0] want_fe, input string nm);
    @(posedge clk); #1;
    expected3 = exp_v;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    checks++; if ({busy3, done3, sel3} !== 5'b10_000) $display("FAIL %s_start: busy/done/sel got %b want 10000", nm, {busy3, done3, sel3}); else passed++;
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      checks++; if ({busy3, done3, sel3} !== {2'b10, 3'(i)}) $display("FAIL %s_step%0d: busy/done/sel got %b want %b", nm, i, {busy3, done3, sel3}, {2'b10, 3'(i)}); else passed++;
    end
    @(posedge clk); #1;
    checks++; if ({busy3, done3, sel3} !== 5'b01_000) $display("FAIL %s_done: busy/done/sel got %b want 01000", nm, {busy3, done3, sel3}); else passed++;
    checks++; if (tbl3 !== want_tbl) $display("FAIL %s_table: got %h want %h", nm, tbl3, want_tbl); else passed++;
    checks++; if (ones3 !== want_ones) $display("FAIL %s_ones: got %0d want %0d", nm, ones3, want_ones); else passed++;
    checks++; if (mm3 !== want_mm) $display("FAIL %s_mismatch: got %b want %b", nm, mm3, want_mm); else passed++;
    checks++; if (fe3 !== want_fe) $display("FAIL %s_first_err: got %0d want %0d", nm, fe3, want_fe); else passed++;
  endtask

  task automatic test_basic();
    fand = 1'b0;
    sweep3(8'hFE, 8'hFE, 4'd7, 1'b0, 3'd0, "or_match");
  endtask

  task automatic test_mismatch();
    sweep3(8'h7E, 8'hFE, 4'd7, 1'b1, 3'd7, "exp7E");
    sweep3(8'hFF, 8'hFE, 4'd7, 1'b1, 3'd0, "expFF");
  endtask

  task automatic test_ignore_and_reset();
    // start pulses at sweep cycles 2 and 5 carry a bogus expected table
    @(posedge clk); #1;
    expected3 = 8'hFE; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    for (int c = 1; c < 8; c++) begin
      @(posedge clk); #1;
      start3 = 1'b0; expected3 = 8'hFE;
      checks++; if ({busy3, sel3} !== {1'b1, 3'(c)}) $display("FAIL ignore_step%0d: busy/sel got %b want %b", c, {busy3, sel3}, {1'b1, 3'(c)}); else passed++;
      if (c == 2 || c == 5) begin
        start3 = 1'b1; expected3 = 8'h00;
      end
    end
    @(posedge clk); #1;
    start3 = 1'b0; expected3 = 8'hFE;
    checks++; if ({done3, tbl3, mm3} !== {1'b1, 8'hFE, 1'b0}) $display("FAIL ignore_result: done/table/mm got %h want %h", {done3, tbl3, mm3}, {1'b1, 8'hFE, 1'b0}); else passed++;
    // abort mid-sweep with an asynchronous reset at cycle 4
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if ({busy3, sel3, ones3} !== {1'b1, 3'd4, 4'd3}) $display("FAIL abort_pre: busy/sel/ones got %h want %h", {busy3, sel3, ones3}, {1'b1, 3'd4, 4'd3}); else passed++;
    areset = 1'b1;
    #1;
    checks++; if ({busy3, done3, mm3, sel3, fe3} !== 9'd0) $display("FAIL abort_flags: got %h want 0", {busy3, done3, mm3, sel3, fe3}); else passed++;
    checks++; if ({tbl3, ones3} !== 12'd0) $display("FAIL abort_results: got %h want 0", {tbl3, ones3}); else passed++;
    @(posedge clk); #1;
    areset = 1'b0;
    sweep3(8'hFE, 8'hFE, 4'd7, 1'b0, 3'd0, "after_reset");
  endtask

  task automatic test_restart_and();
    // u3 sits in DONE here; swap the datapath function and restart
    fand = 1'b1;
    @(posedge clk); #1;
    checks++; if (done3 !== 1'b1) $display("FAIL restart_pre_done: got %b want 1", done3); else passed++;
    sweep3(8'h80, 8'h80, 4'd1, 1'b0, 3'd0, "and_restart");
    fand = 1'b0;
  endtask

  task automatic test_settle3();
    @(posedge clk); #1;
    expected3s = 8'hFE; start3s = 1'b1;
    @(posedge clk); #1;
    start3s = 1'b0;
    for (int c = 0; c < 24; c++) begin
      checks++; if ({busy3s, done3s, sel3s} !== {2'b10, 3'(c / 3)}) $display("FAIL settle3_cyc%0d: busy/done/sel got %b want %b", c, {busy3s, done3s, sel3s}, {2'b10, 3'(c / 3)}); else passed++;
      @(posedge clk); #1;
    end
    checks++; if ({busy3s, done3s, sel3s} !== 5'b01_000) $display("FAIL settle3_done: got %b want 01000", {busy3s, done3s, sel3s}); else passed++;
    checks++; if ({tbl3s, ones3s, mm3s} !== {8'hFE, 4'd7, 1'b0}) $display("FAIL settle3_result: got %h want %h", {tbl3s, ones3s, mm3s}, {8'hFE, 4'd7, 1'b0}); else passed++;
  endtask

  task automatic test_n2();
    @(posedge clk); #1;
    expected2 = 4'hE; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++; if ({busy2, sel2} !== {1'b1, 2'(c)}) $display("FAIL n2_cyc%0d: busy/sel got %b want %b", c, {busy2, sel2}, {1'b1, 2'(c)}); else passed++;
      @(posedge clk); #1;
    end
    checks++; if ({busy2, done2} !== 2'b01) $display("FAIL n2_done: busy/done got %b want 01", {busy2, done2}); else passed++;
    checks++; if (tbl2 !== 4'hE) $display("FAIL n2_table: got %h want e", tbl2); else passed++;
    checks++; if (ones2 !== 3'd3) $display("FAIL n2_ones: got %0d want 3", ones2); else passed++;
    checks++; if ({mm2, fe2} !== 3'd0) $display("FAIL n2_mm_ferr: got %b want 000", {mm2, fe2}); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mismatch();
    test_ignore_and_reset();
    test_restart_and();
    test_settle3();
    test_n2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
